// File: rtl/dcache_core_responder.sv
// Core-side cache bus responder: accepts one request at a time and services it
// against a word-addressed backing store after a fixed LATENCY.
module dcache_core_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4,
    parameter int TAG_W   = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reqcyc,
    input  logic [63:0]      req,
    input  logic [TAG_W-1:0] reqtag,
    input  logic [63:0]      reqdata,
    output logic             reqack,
    output logic             writeack,
    output logic             respcyc,
    output logic [63:0]      resp,
    output logic [TAG_W-1:0] resptag,
    input  logic             respack,
    output logic             busy
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [63:0]        data_q, data_d;
    logic               reqack_q, reqack_d;
    logic               writeack_q, writeack_d;
    logic               respcyc_q, respcyc_d;
    logic [63:0]        resp_q, resp_d;
    logic [TAG_W-1:0]   resptag_q, resptag_d;
    logic               mem_we;

    logic [63:0] mem_q [DEPTH] = '{default: '0};

    // Byte offset and address bits above the store are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^{req[63:3+IDX_W], req[2:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        tag_d      = tag_q;
        data_d     = data_q;
        reqack_d   = 1'b0;
        writeack_d = 1'b0;
        respcyc_d  = respcyc_q;
        resp_d     = resp_q;
        resptag_d  = resptag_q;
        mem_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // The writeack cycle counts as the mandatory gap after a write.
                if (reqcyc && !writeack_q) begin
                    idx_d    = req[3 +: IDX_W];
                    tag_d    = reqtag;
                    data_d   = reqdata;
                    cnt_d    = 8'(LATENCY);
                    reqack_d = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= 8'd1) begin
                    if (tag_q[TAG_W-1]) begin
                        respcyc_d = 1'b1;
                        resp_d    = mem_q[idx_q];
                        resptag_d = tag_q;
                        state_d   = RESP;
                    end else begin
                        mem_we     = 1'b1;
                        writeack_d = 1'b1;
                        state_d    = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                if (respack) begin
                    respcyc_d = 1'b0;
                    resp_d    = '0;
                    resptag_d = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            reqack_q   <= 1'b0;
            writeack_q <= 1'b0;
            respcyc_q  <= 1'b0;
            resp_q     <= '0;
            resptag_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reqack_q   <= reqack_d;
            writeack_q <= writeack_d;
            respcyc_q  <= respcyc_d;
            resp_q     <= resp_d;
            resptag_q  <= resptag_d;
        end
    end

    // Latched request fields need no reset: they are only consumed from WAIT.
    always_ff @(posedge clk) begin
        idx_q  <= idx_d;
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[idx_q] <= data_q;
        end
    end

    assign reqack   = reqack_q;
    assign writeack = writeack_q;
    assign respcyc  = respcyc_q;
    assign resp     = resp_q;
    assign resptag  = resptag_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dcache_core_responder.sv
// Bench for dcache_core_responder: directed scenarios plus random traffic
// checked against an array model of the backing store.
module tb_dcache_core_responder;

    localparam int LAT   = 4;
    localparam int TAG_W = 13;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             reqcyc = 1'b0;
    logic [63:0]      req = '0;
    logic [TAG_W-1:0] reqtag = '0;
    logic [63:0]      reqdata = '0;
    logic             reqack, writeack, respcyc, busy;
    logic [63:0]      resp;
    logic [TAG_W-1:0] resptag;
    logic             respack = 1'b0;

    logic             reqcyc1 = 1'b0;
    logic [63:0]      req1 = '0;
    logic [TAG_W-1:0] reqtag1 = '0;
    logic [63:0]      reqdata1 = '0;
    logic             reqack1, writeack1, respcyc1, busy1;
    logic [63:0]      resp1;
    logic [TAG_W-1:0] resptag1;
    logic             respack1 = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] ref_mem [1024];

    always #5 clk = ~clk;

    dcache_core_responder #(.DEPTH(1024), .LATENCY(LAT), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .reset(reset), .reqcyc(reqcyc), .req(req), .reqtag(reqtag),
        .reqdata(reqdata), .reqack(reqack), .writeack(writeack), .respcyc(respcyc),
        .resp(resp), .resptag(resptag), .respack(respack), .busy(busy)
    );

    dcache_core_responder #(.DEPTH(1024), .LATENCY(1), .TAG_W(TAG_W)) u_dut1 (
        .clk(clk), .reset(reset), .reqcyc(reqcyc1), .req(req1), .reqtag(reqtag1),
        .reqdata(reqdata1), .reqack(reqack1), .writeack(writeack1), .respcyc(respcyc1),
        .resp(resp1), .resptag(resptag1), .respack(respack1), .busy(busy1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_outs"}, {reqack, writeack, respcyc, busy}, 4'b0);
        check_eq({tag, "_resp"}, resp, 64'h0);
        check_eq({tag, "_tag"}, 64'(resptag), 64'h0);
    endtask

    // One complete transaction with cycle-exact latency checks.
    task automatic do_txn(input logic [63:0] addr, input bit rd, input logic [11:0] opq,
                          input logic [63:0] data, input int hold, input bit keep_req);
        logic [9:0]  idx;
        logic [63:0] exp;
        idx     = addr[12:3];
        reqcyc  = 1'b1;
        req     = addr;
        reqtag  = {rd, opq};
        reqdata = data;
        tick;
        if (!keep_req) reqcyc = 1'b0;
        check_eq("reqack", 64'(reqack), 64'h1);
        check_eq("early_done", {writeack, respcyc}, 2'b00);
        for (int k = 1; k < LAT; k++) begin
            tick;
            check_eq("reqack_pulse", 64'(reqack), 64'h0);
            check_eq("wait_done", {writeack, respcyc, busy}, 3'b001);
        end
        tick;
        if (rd) begin
            exp = ref_mem[idx];
            check_eq("respcyc", {respcyc, writeack}, 2'b10);
            check_eq("resp", resp, exp);
            check_eq("resptag", 64'(resptag), 64'({rd, opq}));
            for (int h = 0; h < hold; h++) begin
                tick;
                check_eq("hold_respcyc", 64'(respcyc), 64'h1);
                check_eq("hold_resp", resp, exp);
                check_eq("hold_tag", 64'(resptag), 64'({rd, opq}));
            end
            respack = 1'b1;
            tick;
            respack = 1'b0;
            check_quiet("resp_done");
        end else begin
            check_eq("writeack", {writeack, respcyc, reqack}, 3'b100);
            ref_mem[idx] = data;
            tick;
            check_eq("writeack_pulse", {writeack, reqack}, 2'b00);
        end
    endtask

    initial begin
        logic [63:0] a, d;
        bit          rd;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

        tick; tick;
        reset = 1'b0;
        check_quiet("reset");

        // Write then read at the base latency
        do_txn(64'h1000, 1'b0, 12'h012, 64'hDEADBEEF_CAFEF00D, 0, 1'b0);
        tick;
        do_txn(64'h1000, 1'b1, 12'h345, 64'h0, 0, 1'b0);
        check_eq("t1_model", ref_mem[512], 64'hDEADBEEF_CAFEF00D);

        // Address wrap and ignored byte offset
        do_txn(64'h2007, 1'b0, 12'h001, 64'h5A, 0, 1'b0);
        do_txn(64'h0000, 1'b1, 12'h002, 64'h0, 1, 1'b0);
        do_txn(64'h2000, 1'b1, 12'h003, 64'h0, 0, 1'b0);

        // reqcyc held through WAIT, then a second accepted request
        do_txn(64'h0100, 1'b0, 12'h0AA, 64'h1234_5678_9ABC_DEF0, 0, 1'b1);
        do_txn(64'h0108, 1'b0, 12'h0BB, 64'h0FED_CBA9_8765_4321, 0, 1'b0);
        do_txn(64'h0100, 1'b1, 12'h0CC, 64'h0, 0, 1'b0);

        // Reset mid-write abandons the write
        reqcyc = 1'b1; req = 64'h40; reqtag = {1'b0, 12'h777}; reqdata = 64'h11;
        tick;
        reqcyc = 1'b0;
        tick; tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_quiet("mid_reset");
        for (int k = 0; k < LAT + 2; k++) begin
            tick;
            check_eq("no_writeack", {writeack, busy}, 2'b00);
        end
        do_txn(64'h40, 1'b1, 12'h778, 64'h0, 0, 1'b0);

        // Response held while respack is withheld
        do_txn(64'h1000, 1'b1, 12'hABC, 64'h0, 6, 1'b0);

        // Random traffic, biased toward a few indices for read-after-write hits
        for (int n = 0; n < 60; n++) begin
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) a[12:3] = 10'($urandom_range(0, 7));
            d  = {$urandom, $urandom};
            rd = 1'($urandom_range(0, 1));
            do_txn(a, rd, 12'($urandom), d, $urandom_range(0, 3), 1'b0);
        end

        // LATENCY=1 instance
        reqcyc1 = 1'b1; req1 = 64'h8; reqtag1 = {1'b0, 12'h021}; reqdata1 = 64'hA5A5_0000_1111_5A5A;
        tick;
        reqcyc1 = 1'b0;
        check_eq("l1_reqack", {reqack1, writeack1}, 2'b10);
        tick;
        check_eq("l1_writeack", {reqack1, writeack1}, 2'b01);
        tick;
        check_eq("l1_writeack_pulse", {writeack1, busy1}, 2'b00);
        reqcyc1 = 1'b1; req1 = 64'h8; reqtag1 = {1'b1, 12'h022};
        tick;
        reqcyc1 = 1'b0;
        check_eq("l1_rd_reqack", {reqack1, respcyc1}, 2'b10);
        tick;
        check_eq("l1_respcyc", 64'(respcyc1), 64'h1);
        check_eq("l1_resp", resp1, 64'hA5A5_0000_1111_5A5A);
        check_eq("l1_resptag", 64'(resptag1), 64'({1'b1, 12'h022}));
        respack1 = 1'b1;
        tick;
        respack1 = 1'b0;
        check_eq("l1_done", {respcyc1, busy1}, 2'b00);
        check_eq("l1_done_resp", resp1, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_core_responder.md
Name: dcache_core_responder

Overview:
Responder end of the core-side cache bus. Data-side pipeline stages (writeback, memory-read) drive reqcyc/req/reqtag/reqdata as initiators. This block accepts one request at a time, acknowledges it, and services it against an internal word-addressed backing store after a fixed latency. Reads are returned on respcyc/resp/resptag with a respack handshake; writes complete with a one-cycle writeack pulse. It stands in for the L1 data cache during core bring-up and pipeline verification.

Parameters:
DEPTH, 1024, number of 64-bit words in backing store (power of 2)
LATENCY, 4, cycles from reqack to completion (writeack or respcyc rise); legal range 1..255
TAG_W, 13, reqtag/resptag width; bit TAG_W-1 is direction: 1=READ, 0=WRITE

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
reqcyc  in  1  initiator request valid
req  in  64  byte address
reqtag  in  TAG_W  request tag; MSB = READ(1)/WRITE(0); other bits opaque, echoed on reads
reqdata  in  64  write data
reqack  out  1  one-cycle pulse: request accepted
writeack  out  1  one-cycle pulse: write committed
respcyc  out  1  read response valid; held until respack
resp  out  64  read data
resptag  out  TAG_W  latched reqtag of the read being answered
respack  in  1  initiator consumed response
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: one clock, reset high at the edge. All outputs 0 and state IDLE at the next edge, whatever the current state; any in-flight request is abandoned, and an abandoned write does not modify the store. Store contents are not cleared. The store initializes to zero at time 0.
- Index: word index = req[3 +: log2(DEPTH)]. req[2:0] is ignored (writes are full 64-bit). Upper address bits are ignored, so addresses wrap modulo DEPTH*8.
- State ACCEPT_IDLE (IDLE):
  - On an edge with reqcyc=1, latch req, reqtag and reqdata, set reqack=1 for the following cycle only, and load counter=LATENCY.
  - Go to WAIT.
- State WAIT:
  - reqcyc is ignored; the initiator holds it at most one cycle past reqack.
  - The counter decrements each edge.
  - When the counter reaches 1 (at that edge) with a WRITE tag: write the store, pulse writeack for exactly one cycle, return to IDLE.
  - When the counter reaches 1 with a READ tag: set respcyc=1, resp=store[index], resptag=latched tag, go to RESP.
- Timing: reqcyc sampled at edge t gives reqack high during cycle t+1, and writeack or respcyc rising at cycle t+1+LATENCY.
- State RESP:
  - respcyc, resp and resptag stay constant until respack is sampled high.
  - At that edge respcyc goes to 0 and the state returns to IDLE.
  - If respack is already high on the first RESP cycle, respcyc is high for exactly one cycle.
- Back-to-back requests: IDLE is re-entered on the edge that produces respcyc=0 (reads) or writeack=0 (writes). A new request is accepted at the earliest edge after that, so there is at least one idle cycle between transactions.
- Ordering: a read following a write to the same index returns the new data.
- Outputs: resp and resptag are 0 whenever respcyc=0. reqack and writeack never overlap.
- Counter width: 8 bits. LATENCY=1 gives writeack/respcyc in the cycle right after reqack.

Test Plan:
1. Write then read, LATENCY=4: write req=0x1000, data 0xDEADBEEF_CAFEF00D with reqcyc at edge 0 gives reqack in cycle 1 and writeack in cycle 5. A read of 0x1000 issued in cycle 7 returns respcyc in cycle 12 with resp=0xDEADBEEF_CAFEF00D and resptag equal to the request tag.
2. Respack hold: read with respack withheld for 6 cycles gives respcyc, resp and resptag stable for 7 cycles, then low one cycle after respack is sampled.
3. Wrap and misalignment, DEPTH=1024: write 0x5A to 0x2007, then read 0x0000 + 0x2000 alias. Address 0x2007 maps to index 0 (0x2000 modulo 8192 is 0 and the low 3 bits are ignored), so reading 0x0000 returns 0x5A.
4. Reqcyc held high through WAIT: only one reqack is seen and the store is written exactly once. A second request accepted after IDLE produces a second reqack.
5. Reset mid-operation: assert reset in cycle 3 of a write to 0x40 (data 0x11). All outputs go low, no writeack is issued, and a later read of 0x40 returns the prior value 0.
6. LATENCY=1: write then read to 0x8 gives writeack in cycle 2 and respcyc in cycle 2 of the read, returning the written data.
